// File: rtl/copy_scheduler_if.sv
// copy_scheduler_if: requester, ROM and RAM signals of the block-copy engine
interface copy_scheduler_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              start_sig0;
  logic              start_sig1;
  logic [ADDR_W-1:0] src0;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] dst0;
  logic [ADDR_W-1:0] dst1;
  logic [ADDR_W:0]   len0;
  logic [ADDR_W:0]   len1;
  logic              done_sig0;
  logic              done_sig1;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              write_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              busy;
  logic              grant;
  modport master (
    output start_sig0, start_sig1, src0, src1, dst0, dst1, len0, len1, rom_data,
    input  done_sig0, done_sig1, rom_addr, write_en, ram_addr, ram_data, busy, grant
  );
  modport slave (
    input  start_sig0, start_sig1, src0, src1, dst0, dst1, len0, len1, rom_data,
    output done_sig0, done_sig1, rom_addr, write_en, ram_addr, ram_data, busy, grant
  );
endinterface

// File: rtl/copy_scheduler.sv
// copy_scheduler: round-robin ROM->RAM block-copy engine shared by two requesters
module copy_scheduler #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input logic             clk,
  input logic             rst_n,
  copy_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COPY, DRAIN, DONE} state_t;
  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  state_t            r_state;
  logic              r_busy, r_grant, r_ptr, r_cool, r_done0, r_done1, r_iss;
  logic [ADDR_W-1:0] r_rom_addr, r_wa, r_src, r_dst;
  logic [ADDR_W:0]   r_rem;
  logic [2:0]        r_dc;
  logic              r_pv [ROM_LAT];
  logic [ADDR_W-1:0] r_pa [ROM_LAT];
  logic              w_pick;
  logic [ADDR_W-1:0] w_src, w_dst;
  logic [ADDR_W:0]   w_len_raw, w_len;
  // Both requesting: take the round-robin favourite; otherwise whichever is asking
  always_comb begin
    w_pick    = (bus.start_sig0 & bus.start_sig1) ? r_ptr : bus.start_sig1;
    w_src     = w_pick ? bus.src1 : bus.src0;
    w_dst     = w_pick ? bus.dst1 : bus.dst0;
    w_len_raw = w_pick ? bus.len1 : bus.len0;
    w_len     = (w_len_raw > FULL_LEN) ? FULL_LEN : w_len_raw;
  end
  // Job FSM; r_cool inserts one idle cycle after each job before re-arbitrating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_grant    <= 1'b0;
      r_ptr      <= 1'b0;
      r_cool     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_iss      <= 1'b0;
      r_rom_addr <= '0;
      r_wa       <= '0;
      r_src      <= '0;
      r_dst      <= '0;
      r_rem      <= '0;
      r_dc       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_cool) r_cool <= 1'b0;
          else if (bus.start_sig0 | bus.start_sig1) begin
            r_grant <= w_pick;
            r_busy  <= 1'b1;
            if (w_len == '0) begin
              r_state <= DONE;
              r_done0 <= ~w_pick;
              r_done1 <= w_pick;
            end else begin
              r_state    <= COPY;
              r_iss      <= 1'b1;
              r_rom_addr <= w_src;
              r_wa       <= w_dst;
              r_src      <= w_src + 1'b1;
              r_dst      <= w_dst + 1'b1;
              r_rem      <= w_len - 1'b1;
            end
          end
        end
        COPY: begin
          if (r_rem == '0) begin
            r_state    <= DRAIN;
            r_iss      <= 1'b0;
            r_rom_addr <= '0;
            r_wa       <= '0;
            r_dc       <= 3'(ROM_LAT - 1);
          end else begin
            r_rom_addr <= r_src;
            r_wa       <= r_dst;
            r_src      <= r_src + 1'b1;
            r_dst      <= r_dst + 1'b1;
            r_rem      <= r_rem - 1'b1;
          end
        end
        DRAIN: begin
          if (r_dc == '0) begin
            r_state <= DONE;
            r_done0 <= ~r_grant;
            r_done1 <= r_grant;
          end else r_dc <= r_dc - 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_busy  <= 1'b0;
          r_ptr   <= ~r_grant;
          r_cool  <= 1'b1;
        end
      endcase
    end
  end
  // Delay issue flag and write address by ROM_LAT to meet the returning ROM data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pa[i] <= '0;
      end
    end else begin
      r_pv[0] <= r_iss;
      r_pa[0] <= r_wa;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
      end
    end
  end
  assign bus.rom_addr  = r_rom_addr;
  assign bus.write_en  = r_pv[ROM_LAT-1];
  assign bus.ram_addr  = r_pa[ROM_LAT-1];
  assign bus.ram_data  = r_pv[ROM_LAT-1] ? bus.rom_data : '0;
  assign bus.busy      = r_busy;
  assign bus.grant     = r_grant;
  assign bus.done_sig0 = r_done0;
  assign bus.done_sig1 = r_done1;
endmodule

// File: tb/tb_copy_scheduler.sv
// tb_copy_scheduler: directed vector bench for copy_scheduler at ROM_LAT 1 and 3
module tb_copy_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic       sel = 1'b0;
  logic       s0 = 1'b0, s1 = 1'b0;
  logic [3:0] src0 = '0, src1 = '0, dst0 = '0, dst1 = '0;
  logic [4:0] len0 = '0, len1 = '0;
  int n_tests = 0, n_fail = 0;
  copy_scheduler_if #(.ADDR_W(4), .DATA_W(8)) if1 ();
  copy_scheduler_if #(.ADDR_W(4), .DATA_W(8)) if3 ();
  copy_scheduler #(.ADDR_W(4), .DATA_W(8), .ROM_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  copy_scheduler #(.ADDR_W(4), .DATA_W(8), .ROM_LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  assign if1.start_sig0 = s0 & ~sel;
  assign if1.start_sig1 = s1 & ~sel;
  assign if3.start_sig0 = s0 & sel;
  assign if3.start_sig1 = s1 & sel;
  assign if1.src0 = src0; assign if1.src1 = src1; assign if1.dst0 = dst0; assign if1.dst1 = dst1;
  assign if1.len0 = len0; assign if1.len1 = len1;
  assign if3.src0 = src0; assign if3.src1 = src1; assign if3.dst0 = dst0; assign if3.dst1 = dst1;
  assign if3.len0 = len0; assign if3.len1 = len1;
  function automatic logic [7:0] romv(input logic [3:0] a);
    return {4'h0, a} + 8'h10;
  endfunction
  logic [7:0] rp1;
  logic [7:0] rp3 [3];
  always @(posedge clk) begin
    rp1    <= romv(if1.rom_addr);
    rp3[0] <= romv(if3.rom_addr);
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign if1.rom_data = rp1;
  assign if3.rom_data = rp3[2];
  logic       m_we, m_busy, m_grant, m_d0, m_d1;
  logic [3:0] m_ra, m_wa;
  logic [7:0] m_wd;
  always_comb begin
    m_we    = sel ? if3.write_en  : if1.write_en;
    m_busy  = sel ? if3.busy      : if1.busy;
    m_grant = sel ? if3.grant     : if1.grant;
    m_d0    = sel ? if3.done_sig0 : if1.done_sig0;
    m_d1    = sel ? if3.done_sig1 : if1.done_sig1;
    m_ra    = sel ? if3.rom_addr  : if1.rom_addr;
    m_wa    = sel ? if3.ram_addr  : if1.ram_addr;
    m_wd    = sel ? if3.ram_data  : if1.ram_data;
  end
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  typedef struct {
    logic       sel;
    logic       ch;
    logic [3:0] src;
    logic [3:0] dst;
    logic [4:0] len;
    int         first;
    int         nwr;
    int         done;
  } vec_t;
  vec_t vt [8];
  task automatic run_job(input vec_t v);
    int first = -1, nwr = 0, done_c = -1, rom_err = 0, wr_err = 0, other = 0, gr = -1;
    logic [3:0] ea, sa;
    sel = v.sel;
    src0 = v.src; src1 = v.src; dst0 = v.dst; dst1 = v.dst; len0 = v.len; len1 = v.len;
    @(negedge clk);
    if (v.ch) s1 = 1'b1; else s0 = 1'b1;
    for (int cyc = 1; cyc <= 40 && done_c < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) gr = int'(m_grant);
      ea = (cyc <= v.nwr) ? v.src + 4'(cyc - 1) : 4'h0;
      if (m_ra != ea) rom_err++;
      if (m_we) begin
        if (first < 0) first = cyc;
        sa = v.src + 4'(nwr);
        if (cyc != v.first + nwr || m_wa != v.dst + 4'(nwr) || m_wd != romv(sa)) wr_err++;
        nwr++;
      end
      if (v.ch ? m_d0 : m_d1) other++;
      if (v.ch ? m_d1 : m_d0) begin
        done_c = cyc;
        s0 = 1'b0;
        s1 = 1'b0;
      end
    end
    @(negedge clk);
    check("job_grant", gr, int'(v.ch));
    check("job_first_write", first, v.first);
    check("job_write_count", nwr, v.nwr);
    check("job_done_cycle", done_c, v.done);
    check("job_rom_addr_errors", rom_err, 0);
    check("job_write_errors", wr_err, 0);
    check("job_wrong_done", other, 0);
    check("job_idle_after", int'({m_busy, m_we, m_d0, m_d1}), 0);
    @(negedge clk);
  endtask
  initial begin
    int d0c, d1c, first1, nw, ga, gb, ng, d0n, d1n;
    logic prev_busy;
    int gseq [4];
    vt[0] = '{1'b0, 1'b0, 4'd0,  4'd0,  5'd16, 2, 16, 18};
    vt[1] = '{1'b0, 1'b1, 4'd14, 4'd15, 5'd4,  2, 4,  6};
    vt[2] = '{1'b0, 1'b0, 4'd5,  4'd3,  5'd0, -1, 0,  1};
    vt[3] = '{1'b0, 1'b0, 4'd3,  4'd9,  5'd31, 2, 16, 18};
    vt[4] = '{1'b0, 1'b1, 4'd5,  4'd2,  5'd1,  2, 1,  3};
    vt[5] = '{1'b0, 1'b1, 4'd15, 4'd7,  5'd17, 2, 16, 18};
    vt[6] = '{1'b1, 1'b0, 4'd4,  4'd8,  5'd8,  4, 8,  12};
    vt[7] = '{1'b1, 1'b1, 4'd13, 4'd1,  5'd3,  4, 3,  7};
    repeat (3) @(negedge clk);
    check("reset_outputs_u1", int'({if1.write_en, if1.busy, if1.grant, if1.done_sig0, if1.done_sig1,
          if1.rom_addr, if1.ram_addr, if1.ram_data}), 0);
    check("reset_outputs_u3", int'({if3.write_en, if3.busy, if3.grant, if3.done_sig0, if3.done_sig1,
          if3.rom_addr, if3.ram_addr, if3.ram_data}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    // both channels request right after reset: ch0 then ch1
    sel = 1'b0;
    src0 = 4'd0; dst0 = 4'd0; len0 = 5'd4; src1 = 4'd8; dst1 = 4'd4; len1 = 5'd4;
    d0c = -1; d1c = -1; first1 = -1; nw = 0; ga = -1; gb = -1;
    s0 = 1'b1; s1 = 1'b1;
    for (int cyc = 1; cyc <= 40 && d1c < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) ga = int'(m_grant);
      if (cyc == 9) gb = int'(m_grant);
      if (m_we) begin
        nw++;
        if (first1 < 0 && d0c >= 0) first1 = cyc;
      end
      if (m_d0) begin d0c = cyc; s0 = 1'b0; end
      if (m_d1) begin d1c = cyc; s1 = 1'b0; end
    end
    check("rr_first_grant", ga, 0);
    check("rr_second_grant", gb, 1);
    check("rr_done0_cycle", d0c, 6);
    check("rr_done1_cycle", d1c, 14);
    check("rr_ch1_first_write", first1, 10);
    check("rr_total_writes", nw, 8);
    repeat (2) @(negedge clk);
    foreach (vt[i]) run_job(vt[i]);
    // reset in the middle of a 16-word job
    sel = 1'b0;
    src0 = 4'd0; dst0 = 4'd0; len0 = 5'd16; nw = 0;
    s0 = 1'b1;
    for (int cyc = 1; cyc <= 30 && nw < 5; cyc++) begin
      @(negedge clk);
      if (m_we) nw++;
    end
    check("abort_writes_before_reset", nw, 5);
    rst_n = 1'b0;
    #1;
    check("abort_outputs_zero", int'({if1.write_en, if1.busy, if1.rom_addr, if1.ram_data}), 0);
    d0n = 0; d1n = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_d0 | m_d1) d0n++;
    end
    check("abort_no_done", d0n, 0);
    // after release both request continuously; grants must alternate starting with ch0
    len0 = 5'd2; len1 = 5'd2; src1 = 4'd6; dst1 = 4'd9;
    s1 = 1'b1;
    rst_n = 1'b1;
    ng = 0; d0n = 0; d1n = 0; prev_busy = 1'b0;
    for (int cyc = 1; cyc <= 80 && ng < 4; cyc++) begin
      @(negedge clk);
      if (m_busy && !prev_busy) begin
        gseq[ng] = int'(m_grant);
        ng++;
      end
      prev_busy = m_busy;
      if (m_d0) d0n++;
      if (m_d1) d1n++;
    end
    check("fair_grant_count", ng, 4);
    for (int i = 0; i < 4; i++) check("fair_grant_order", gseq[i], i % 2);
    check("fair_done0_count", d0n, 2);
    check("fair_done1_count", d1n, 1);
    s0 = 1'b0; s1 = 1'b0;
    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
